// File: rtl/mem_write_buffer.sv
`default_nettype none
// ============================================================================
// mem_write_buffer : circular store buffer draining to SRAM; loads wait for
//                    the drain, or forward from it when WBUF_STORE_FWD_EN is set.
// Revision 1.0
// ============================================================================
module mem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        stall,
  output logic        sram_wr_en,
  output logic        sram_rd_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_addr_mem [DEPTH];
  logic [31:0]        r_data_mem [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;
  logic w_rd_go;
  logic w_unused;

  assign w_unused = ^rd_addr[1:0];

  // A pop completing this cycle frees a slot, so a full buffer still accepts.
  assign w_pop  = (r_state == ST_WRITE) && sram_ready;
  assign w_push = wr_req && ((r_count != c_FULL) || w_pop);
  assign stall  = (rd_req && !rd_valid) || (wr_req && !w_push);

`ifdef WBUF_STORE_FWD_EN
  logic        w_fwd_hit;
  logic [31:0] w_fwd_data;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((c_CNT_W'(i) < r_count) &&
          (r_addr_mem[r_head + c_PTR_W'(i)][31:2] == rd_addr[31:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data_mem[r_head + c_PTR_W'(i)];
      end
    end
  end

  assign w_rd_go = rd_req && !rd_valid && !w_fwd_hit;
`else
  assign w_rd_go = rd_req && !rd_valid && (r_count == '0);
`endif

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr_mem[r_tail] <= wr_addr;
      r_data_mem[r_tail] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + c_PTR_ONE;
      if (w_pop)  r_head <= r_head + c_PTR_ONE;
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      sram_wr_en <= 1'b0;
      sram_rd_en <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rd_go) begin
            r_state    <= ST_READ;
            sram_rd_en <= 1'b1;
            sram_addr  <= {rd_addr[31:3], 3'b000};
          end else if (r_count != '0) begin
            r_state    <= ST_WRITE;
            sram_wr_en <= 1'b1;
            sram_addr  <= r_addr_mem[r_head];
            sram_wdata <= r_data_mem[r_head];
          end
        end
        ST_WRITE: begin
          if (sram_ready) begin
            r_state    <= ST_IDLE;
            sram_wr_en <= 1'b0;
          end
        end
        ST_READ: begin
          if (sram_ready) begin
            r_state    <= ST_IDLE;
            sram_rd_en <= 1'b0;
            rd_valid   <= 1'b1;
            rd_data    <= rd_addr[2] ? sram_rdata[63:32] : sram_rdata[31:0];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef WBUF_STORE_FWD_EN
      // Forwarded loads never touch SRAM, so they complete in any state.
      if (rd_req && !rd_valid && w_fwd_hit) begin
        rd_valid <= 1'b1;
        rd_data  <= w_fwd_data;
      end
`endif
    end
  end

endmodule
`default_nettype wire
